// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the serial adder issue stage.
package serial_add_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_CTRW  = 5;
    localparam int DEF_COUNT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
    } pair_t;

endpackage

// File: rtl/serial_add_seq_fifo.sv
// DEPTH x DW synchronous FIFO with occupancy count; head word is visible combinationally.
module seq_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] wdata,
    input  logic          pop,
    output logic [DW-1:0] rdata,
    output logic [CW-1:0] count,
    output logic          empty
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          wr_en, rd_en;

    // Guard against over/underflow so callers cannot corrupt the pointers.
    assign wr_en = push && (count_q != CW'(DEPTH));
    assign rd_en = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign empty = (count_q == '0);

endmodule

// File: rtl/serial_add_seq.sv
// Issue stage in front of the non-pipelined bit-serial adder: FIFO-buffered operands, one add in flight.
// Optional watchdog on the adder's done: define SERIAL_ADD_SEQ_TMO_EN.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CTRW    = DEF_CTRW,
    parameter int COUNT   = DEF_COUNT,
    parameter int DEPTH   = 4,
    parameter int TMO_CYC = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             add_start,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic [CTRW-1:0]  add_count,
    input  logic             add_done,
    input  logic [WIDTH-1:0] add_sum,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             busy
`ifdef SERIAL_ADD_SEQ_TMO_EN
   ,output logic             tmo_err
`endif
);

    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TMO_CYC < 1) begin : g_bad_cfg
        $error("serial_add_seq: DEPTH must be a power of two >= 2 and TMO_CYC >= 1");
    end

    state_e           state_q, state_d;
    logic             add_start_q, add_start_d;
    logic [WIDTH-1:0] add_a_q, add_a_d;
    logic [WIDTH-1:0] add_b_q, add_b_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_sum_q, out_sum_d;

    logic               fifo_push, fifo_pop, fifo_empty;
    logic [2*WIDTH-1:0] fifo_rdata;
    logic [CW-1:0]      fifo_count;

`ifdef SERIAL_ADD_SEQ_TMO_EN
    localparam int TW = $clog2(TMO_CYC + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;
`endif

    // Full means no push even if a pop happens this cycle; keeps in_ready off the pop path.
    assign in_ready  = (fifo_count != CW'(DEPTH));
    assign fifo_push = in_valid && in_ready;

    seq_fifo #(
        .DEPTH (DEPTH),
        .DW    (2 * WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({in_a, in_b}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        add_start_d = 1'b0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        fifo_pop    = 1'b0;
`ifdef SERIAL_ADD_SEQ_TMO_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
`endif

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
`ifdef SERIAL_ADD_SEQ_TMO_EN
            tmo_err_d   = 1'b0;
`endif
        end

        case (state_q)
            IDLE: begin
                // Single result slot: an unaccepted sum blocks the next issue.
                if (!fifo_empty && !out_valid_q) begin
                    fifo_pop           = 1'b1;
                    {add_a_d, add_b_d} = fifo_rdata;
                    add_start_d        = 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
`ifdef SERIAL_ADD_SEQ_TMO_EN
                tmo_cnt_d = '0;
`endif
            end
            WAIT: begin
                if (add_done) begin
                    out_sum_d   = add_sum;
                    out_valid_d = 1'b1;
                    state_d     = DRAIN;
                end
`ifdef SERIAL_ADD_SEQ_TMO_EN
                else if (tmo_cnt_q == TW'(TMO_CYC - 1)) begin
                    out_sum_d   = '1;
                    out_valid_d = 1'b1;
                    tmo_err_d   = 1'b1;
                    state_d     = DRAIN;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
`endif
            end
            DRAIN: begin
                // done is a level; wait for it to drop so it is never counted twice.
                if (!add_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            add_start_q <= 1'b0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            add_start_q <= add_start_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
        end
    end

`ifdef SERIAL_ADD_SEQ_TMO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end
    assign tmo_err = tmo_err_q;
`endif

    assign add_start = add_start_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_count = CTRW'(COUNT);
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a behavioural 18-cycle serial adder model.
module tb_serial_add_seq;

    localparam int LAT = 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic        add_start;
    logic [15:0] add_a, add_b;
    logic [4:0]  add_count;
    logic        add_done;
    logic [15:0] add_sum;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_sum;
    logic        busy;
`ifdef SERIAL_ADD_SEQ_TMO_EN
    logic        tmo_err;
`endif

    serial_add_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .add_start (add_start),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_count (add_count),
        .add_done  (add_done),
        .add_sum   (add_sum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .busy      (busy)
`ifdef SERIAL_ADD_SEQ_TMO_EN
       ,.tmo_err   (tmo_err)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural serial adder: done rises LAT edges after the edge that samples start.
    int          m_rem = 0;
    logic        m_act = 1'b0;
    logic        m_done = 1'b0;
    int          m_hcnt = 0;
    logic [15:0] m_sum = '0;
    int          hold_len = 1;
    logic        model_en = 1'b1;

    always @(posedge clk) begin
        if (add_start) begin
            m_rem <= LAT;
            m_act <= 1'b1;
            m_sum <= add_a + add_b;
        end else if (m_act) begin
            m_rem <= m_rem - 1;
            if (m_rem == 1) begin
                m_act <= 1'b0;
                if (model_en) begin
                    m_done <= 1'b1;
                    m_hcnt <= hold_len;
                end
            end
        end
        if (m_done) begin
            if (m_hcnt <= 1) m_done <= 1'b0;
            m_hcnt <= m_hcnt - 1;
        end
    end
    assign add_done = m_done;
    assign add_sum  = m_sum;

    // Monitor sampled on the falling edge.
    int   cyc = 0, start_cyc = 0, lat = 0, n_start = 0, n_acc = 0;
    logic ov_prev = 1'b0;
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (add_start) begin
            start_cyc <= cyc;
            n_start   <= n_start + 1;
        end
        if (out_valid && !ov_prev) lat <= cyc - start_cyc;
        ov_prev <= out_valid;
        if (out_valid && out_ready) n_acc <= n_acc + 1;
    end

    int tests = 0, fails = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready), 1);
        chk({tag, "_add_start"}, 32'(add_start), 0);
        chk({tag, "_add_a"},     32'(add_a), 0);
        chk({tag, "_add_b"},     32'(add_b), 0);
        chk({tag, "_add_count"}, 32'(add_count), 16);
        chk({tag, "_out_valid"}, 32'(out_valid), 0);
        chk({tag, "_out_sum"},   32'(out_sum), 0);
        chk({tag, "_busy"},      32'(busy), 0);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("push_timeout", 32'(in_ready), 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    // Caller holds out_ready=1; result is accepted at the following rising edge.
    task automatic get_result(input string name, input logic [15:0] exp, input int exp_lat);
        bit ok;
        wait_valid(300, ok);
        chk({name, "_valid"}, 32'(ok), 1);
        if (ok) begin
            chk({name, "_sum"}, 32'(out_sum), 32'(exp));
            #1;
            chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
            @(posedge clk);
            #1;
        end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] s;
    } vec_t;
    vec_t vt[6];

    initial begin
        int   s0, bad, ns0, na0, k;
        bit   ok;

        vt[0] = '{16'h1234, 16'h0F0F, 16'h2143};
        vt[1] = '{16'hFFFF, 16'h0001, 16'h0000};
        vt[2] = '{16'h8000, 16'h8000, 16'h0000};
        vt[3] = '{16'h7FFF, 16'h0001, 16'h8000};
        vt[4] = '{16'hAAAA, 16'h5555, 16'hFFFF};
        vt[5] = '{16'h0000, 16'h0000, 16'h0000};

        #3 chk_reset("rst0");
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Single ops through the table, each with latency and start-pulse checks.
        out_ready = 1'b1;
        foreach (vt[i]) begin
            ns0 = n_start;
            push(vt[i].a, vt[i].b);
            get_result($sformatf("vec%0d", i), vt[i].s, LAT + 2);
            chk($sformatf("vec%0d_starts", i), 32'(n_start - ns0), 1);
        end

        // Fill the FIFO behind a stalled result, then apply backpressure.
        out_ready = 1'b0;
        push(16'h0010, 16'h0020);
        push(16'd1, 16'd2);
        push(16'd3, 16'd4);
        push(16'd5, 16'd6);
        push(16'd7, 16'd8);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 0);
        chk("full_busy", 32'(busy), 1);
        wait_valid(300, ok);
        chk("bp_valid", 32'(ok), 1);
        s0 = 32'(out_sum);
        chk("bp_sum", 32'(s0), 32'h0030);
        ns0 = n_start;
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (!out_valid || 32'(out_sum) != s0) bad++;
        end
        chk("bp_stable", 32'(bad), 0);
        chk("bp_no_start", 32'(n_start - ns0), 0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        k = -1;
        for (int i = 0; i < 10 && k < 0; i++) begin
            @(negedge clk);
            if (add_start) k = i;
        end
        chk("issue_spacing", 32'(k), 1);
        chk("in_ready_after_pop", 32'(in_ready), 1);
        get_result("b2b0", 16'd3, LAT + 2);
        get_result("b2b1", 16'd7, LAT + 2);
        get_result("b2b2", 16'd11, LAT + 2);
        get_result("b2b3", 16'd15, LAT + 2);

        // Level-high done for 5 cycles must yield one result per add.
        hold_len = 5;
        na0 = n_acc;
        push(16'h0100, 16'h0200);
        push(16'h0400, 16'h0500);
        get_result("hold0", 16'h0300, LAT + 2);
        get_result("hold1", 16'h0900, LAT + 2);
        repeat (30) @(negedge clk);
        chk("hold_count", 32'(n_acc - na0), 2);
        hold_len = 1;

        // Reset mid-WAIT with two pairs queued.
        push(16'h0011, 16'h0022);
        push(16'h0033, 16'h0044);
        push(16'h0055, 16'h0066);
        repeat (6) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 1);
        #2 rst = 1'b1;
        #1 chk_reset("rst_mid");
        ns0 = n_start;
        na0 = n_acc;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid || busy) bad++;
        end
        chk("post_rst_idle", 32'(bad), 0);
        chk("post_rst_no_start", 32'(n_start - ns0), 0);
        chk("post_rst_no_result", 32'(n_acc - na0), 0);
        push(16'h0001, 16'h0002);
        get_result("post_rst", 16'h0003, LAT + 2);

`ifdef SERIAL_ADD_SEQ_TMO_EN
        // No done from the adder: watchdog fires after 64 cycles in WAIT.
        model_en = 1'b0;
        out_ready = 1'b0;
        push(16'h1111, 16'h2222);
        push(16'h0003, 16'h0004);
        wait_valid(300, ok);
        chk("tmo_valid", 32'(ok), 1);
        chk("tmo_err", 32'(tmo_err), 1);
        chk("tmo_sum", 32'(out_sum), 32'hFFFF);
        #1 chk("tmo_lat", 32'(lat), 65);
        model_en = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 chk("tmo_err_clr", 32'(tmo_err), 0);
        get_result("tmo_next", 16'h0007, LAT + 2);
        chk("tmo_next_err", 32'(tmo_err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
